// File: rtl/dl_token_monitor_pkg.sv
// Shared definitions for the per-process deadlock token monitor.
// Contents:
//   CNT_W          - width of the block-persistence counter
//   MAX_PROC       - widest process vector the helper function handles
//   dl_state_e     - 3-bit monitor FSM encoding
//   onehot_lowest  - isolates the lowest set bit of a vector
package dl_token_monitor_pkg;

    localparam int CNT_W    = 8;
    localparam int MAX_PROC = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ORIG = 3'd2,
        ST_HOLD = 3'd3,
        ST_PASS = 3'd4,
        ST_DONE = 3'd5
    } dl_state_e;

    // Two's-complement trick: vec & -vec keeps only the lowest set bit;
    // an all-zero vector yields zero.
    function automatic logic [MAX_PROC-1:0] onehot_lowest(input logic [MAX_PROC-1:0] vec);
        return vec & (~vec + {{(MAX_PROC-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/dl_token_monitor_if.sv
// Token-passing link between one monitor and the report unit / peer monitors.
// Signals:
//   dl_detect_in  - global "deadlock detected" level
//   origin_in     - one-cycle origin select, one bit per process
//   token_clear   - end-of-cycle pulse
//   token_in_vec  - bit j: process j hands the token to this monitor
//   token_out_vec - one-hot token handed to the chosen dependency
//   dl_out        - this monitor's bit of the report unit's dl_in_vec
// Modports: master = the monitor, slave = report unit / environment.
interface dl_token_monitor_if #(
    parameter int PROC_NUM = 2
);
    logic                dl_detect_in;
    logic [PROC_NUM-1:0] origin_in;
    logic                token_clear;
    logic [PROC_NUM-1:0] token_in_vec;
    logic [PROC_NUM-1:0] token_out_vec;
    logic                dl_out;

    modport master (
        input  dl_detect_in, origin_in, token_clear, token_in_vec,
        output token_out_vec, dl_out
    );

    modport slave (
        output dl_detect_in, origin_in, token_clear, token_in_vec,
        input  token_out_vec, dl_out
    );
endinterface

// File: rtl/dl_block_persist_cnt.sv
// Block-persistence counter: counts consecutive stalled cycles, saturating
// at BLOCK_THRESH, and flags blk_stable once the threshold is reached.
// Ports:
//   clock, reset  - rising-edge clock, async active-low reset
//   proc_blocked  - process stalled this cycle
//   blk_stable    - counter equals BLOCK_THRESH
module dl_block_persist_cnt
    import dl_token_monitor_pkg::*;
#(
    parameter int BLOCK_THRESH = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic proc_blocked,
    output logic blk_stable
);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(BLOCK_THRESH);

    logic [CNT_W-1:0] cnt_r;

    // Stall counter: count up while blocked, hold at threshold, zero otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!proc_blocked) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == THRESH) begin
            cnt_r <= cnt_r;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign blk_stable = (cnt_r == THRESH);

endmodule

// File: rtl/dl_token_monitor.sv
// Per-process deadlock monitor. Before detection it claims a deadlock when
// its process has been stalled long enough while the whole region stalls;
// after detection it relays the token along the wait-for chain.
// Ports:
//   clock, reset  - rising-edge clock, async active-low reset
//   proc_blocked  - process stalled this cycle
//   dep_vec       - processes this one waits on
//   sys_stalled   - whole region blocked or idle
//   tok_if        - token link (master side), see dl_token_monitor_if
//   token_err     - sticky protocol-violation flag
module dl_token_monitor
    import dl_token_monitor_pkg::*;
#(
    parameter int PROC_NUM     = 2,
    parameter int PROC_IDX     = 0,
    parameter int BLOCK_THRESH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 proc_blocked,
    input  logic [PROC_NUM-1:0]  dep_vec,
    input  logic                 sys_stalled,
    dl_token_monitor_if.master   tok_if,
    output logic                 token_err
);
    localparam logic [PROC_NUM-1:0] ZERO_VEC = {PROC_NUM{1'b0}};

    dl_state_e           state_r, state_s;
    logic                is_orig_r, is_orig_s;
    logic [PROC_NUM-1:0] tgt_r, tgt_s;
    logic                token_err_r, token_err_s;
    logic                blk_stable_s;
    logic                tok_any_s;
    logic                my_orig_s;
    logic [PROC_NUM-1:0] lowest_dep_s;
    logic                dl_out_s;
    logic [PROC_NUM-1:0] tok_out_s;

    dl_block_persist_cnt #(
        .BLOCK_THRESH (BLOCK_THRESH)
    ) u_persist (
        .clock        (clock),
        .reset        (reset),
        .proc_blocked (proc_blocked),
        .blk_stable   (blk_stable_s)
    );

    // Several simultaneous token bits count as a single token.
    assign tok_any_s    = |tok_if.token_in_vec;
    assign my_orig_s    = tok_if.origin_in[PROC_IDX];
    assign lowest_dep_s = PROC_NUM'(onehot_lowest(MAX_PROC'(dep_vec)));

    // State and context registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            is_orig_r   <= 1'b0;
            tgt_r       <= ZERO_VEC;
            token_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            is_orig_r   <= is_orig_s;
            tgt_r       <= tgt_s;
            token_err_r <= token_err_s;
        end
    end

    // Next-state logic: detect-drop beats clear, clear beats everything else.
    always_comb begin
        state_s     = state_r;
        is_orig_s   = is_orig_r;
        tgt_s       = tgt_r;
        token_err_s = token_err_r;
        if (!tok_if.dl_detect_in) begin
            state_s   = ST_IDLE;
            is_orig_s = 1'b0;
        end else if ((state_r != ST_IDLE) && tok_if.token_clear) begin
            state_s   = ST_WAIT;
            is_orig_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_WAIT;
                end
                // ST_DONE only leaves on a new origin select; tokens are held off
                // until a clear has returned the monitor to ST_WAIT.
                ST_WAIT, ST_DONE: begin
                    if (my_orig_s) begin
                        state_s   = ST_PASS;
                        is_orig_s = 1'b1;
                        tgt_s     = lowest_dep_s;
                    end else if (tok_any_s && (state_r == ST_WAIT)) begin
                        state_s   = ST_HOLD;
                        is_orig_s = 1'b0;
                        tgt_s     = lowest_dep_s;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_ORIG: begin
                    if (tok_any_s) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_ORIG;
                    end
                end
                ST_HOLD: begin
                    if (tok_any_s) begin
                        token_err_s = 1'b1;
                    end else begin
                        token_err_s = token_err_r;
                    end
                    if (is_orig_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_PASS;
                    end
                end
                ST_PASS: begin
                    // A missing dependency leaves nobody to pass to.
                    if (tok_any_s || (tgt_r == ZERO_VEC)) begin
                        token_err_s = 1'b1;
                    end else begin
                        token_err_s = token_err_r;
                    end
                    if ((tgt_r != ZERO_VEC) && is_orig_r) begin
                        state_s = ST_ORIG;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    is_orig_s = 1'b0;
                end
            endcase
        end
    end

    // Outputs: only the idle claim depends on live inputs.
    always_comb begin
        dl_out_s  = 1'b0;
        tok_out_s = ZERO_VEC;
        case (state_r)
            ST_IDLE: dl_out_s  = blk_stable_s & sys_stalled & (|dep_vec);
            ST_HOLD: dl_out_s  = 1'b1;
            ST_PASS: tok_out_s = tgt_r;
            default: begin
                dl_out_s  = 1'b0;
                tok_out_s = ZERO_VEC;
            end
        endcase
    end

    assign tok_if.dl_out        = dl_out_s;
    assign tok_if.token_out_vec = tok_out_s;
    assign token_err            = token_err_r;

endmodule

// File: tb/tb_dl_token_monitor.sv
module tb_dl_token_monitor;

    logic       clock;
    logic       reset;
    logic       proc_blocked;
    logic [1:0] dep_vec;
    logic       sys_stalled;
    logic       token_err;

    dl_token_monitor_if #(.PROC_NUM(2)) mon_if ();

    dl_token_monitor #(
        .PROC_NUM     (2),
        .PROC_IDX     (0),
        .BLOCK_THRESH (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .proc_blocked (proc_blocked),
        .dep_vec      (dep_vec),
        .sys_stalled  (sys_stalled),
        .tok_if       (mon_if),
        .token_err    (token_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       pb;
        logic [1:0] dep;
        logic       ss;
        logic       det;
        logic [1:0] org;
        logic       clr;
        logic [1:0] tin;
        logic       edl;
        logic [1:0] etok;
        logic       eerr;
    } vec_t;

    typedef struct {
        int         id;
        logic       dl;
        logic [1:0] tok;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[50];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic pb, logic [1:0] dep, logic ss, logic det,
                                logic [1:0] org, logic clr, logic [1:0] tin,
                                logic edl, logic [1:0] etok, logic eerr);
        vec_t v;
        v.pb = pb; v.dep = dep; v.ss = ss; v.det = det; v.org = org;
        v.clr = clr; v.tin = tin; v.edl = edl; v.etok = etok; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [1:0] got, input logic [1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b, expected %b", nm, id, got, want);
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), then
    // compare the outputs seen after the next rising edge.
    task automatic cyc(input vec_t v, input int id);
        exp_t e;
        proc_blocked         = v.pb;
        dep_vec              = v.dep;
        sys_stalled          = v.ss;
        mon_if.dl_detect_in  = v.det;
        mon_if.origin_in     = v.org;
        mon_if.token_clear   = v.clr;
        mon_if.token_in_vec  = v.tin;
        e.id = id; e.dl = v.edl; e.tok = v.etok; e.err = v.eerr;
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        chk("dl_out",        e.id, {1'b0, mon_if.dl_out}, {1'b0, e.dl});
        chk("token_out_vec", e.id, mon_if.token_out_vec,  e.tok);
        chk("token_err",     e.id, {1'b0, token_err},     {1'b0, e.err});
    endtask

    initial begin
        reset = 1'b0;
        proc_blocked = 1'b0; dep_vec = 2'b00; sys_stalled = 1'b0;
        mon_if.dl_detect_in = 1'b0; mon_if.origin_in = 2'b00;
        mon_if.token_clear = 1'b0; mon_if.token_in_vec = 2'b00;

        //        pb    dep    ss    det   org    clr   tin    edl   etok   eerr
        // persistence, threshold 4
        tbl[0]  = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[1]  = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[2]  = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[3]  = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
        tbl[4]  = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
        tbl[5]  = mk(1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        // blocked run broken at cycle 3
        tbl[6]  = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[7]  = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[8]  = mk(1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[9]  = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[10] = mk(1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        // claim gated by sys_stalled and dep_vec
        tbl[11] = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[12] = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[13] = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[14] = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
        tbl[15] = mk(1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[16] = mk(1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[17] = mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
        // detection: IDLE -> WAIT, claim drops
        tbl[18] = mk(1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        // origin path
        tbl[19] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
        tbl[20] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[21] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[22] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0);
        tbl[23] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[24] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        // relay path, then multi-bit token treated as one
        tbl[25] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0);
        tbl[26] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
        tbl[27] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[28] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0);
        tbl[29] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
        tbl[30] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        // origin without clear -> DONE, held until clear, then re-entered
        tbl[31] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
        tbl[32] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[33] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0);
        tbl[34] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[35] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0);
        tbl[36] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[37] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0);
        tbl[38] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
        tbl[39] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        // clear beats a token in ORIG; afterwards the monitor relays normally
        tbl[40] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
        tbl[41] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[42] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        tbl[43] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0);
        tbl[44] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
        tbl[45] = mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        // empty dependency -> no token out, sticky error
        tbl[46] = mk(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0);
        tbl[47] = mk(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tbl[48] = mk(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        tbl[49] = mk(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

        // reset state
        @(negedge clock);
        @(negedge clock);
        chk("reset dl_out",    -1, {1'b0, mon_if.dl_out}, 2'b00);
        chk("reset token_out", -1, mon_if.token_out_vec,  2'b00);
        chk("reset token_err", -1, {1'b0, token_err},     2'b00);
        reset = 1'b1;

        for (int i = 0; i < 50; i++) begin
            cyc(tbl[i], i);
        end

        // reset in the middle of a pass
        cyc(mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1), 100);
        cyc(mk(1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1), 101);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset dl_out",    102, {1'b0, mon_if.dl_out}, 2'b00);
        chk("midreset token_out", 102, mon_if.token_out_vec,  2'b00);
        chk("midreset token_err", 102, {1'b0, token_err},     2'b00);
        mon_if.dl_detect_in = 1'b0;
        mon_if.token_in_vec = 2'b00;
        @(negedge clock);
        reset = 1'b1;
        // counter restarted from 0 and FSM back in IDLE: claim after 4 blocked cycles
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0), 103);
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0), 104);
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0), 105);
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0), 106);

        // extra token while holding -> error; then detect drop returns to IDLE
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0), 107);
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0), 108);
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 2'b10, 1'b1), 109);
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1), 110);
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1), 111);
        cyc(mk(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1), 112);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
